// File: rtl/vr_pkg.sv
// Shared types, defaults and sizing helpers for the valid/ready FIFO.
// Imported by vr_fifo and vr_fifo_mem.
package vr_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    // Width-parametrised payload type: vr_types#(W)::data_t
    virtual class vr_types #(parameter int W = DATA_W_DEF);
        typedef logic [W-1:0] data_t;
    endclass

    // Bits needed to hold an occupancy of 0..depth
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vr_fifo_mem.sv
// Register-array storage for vr_fifo.
// One write port, one asynchronous read port, contents never reset.
module vr_fifo_mem
    import vr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Capture the write word into the addressed entry
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/vr_fifo.sv
// Valid/ready FIFO: pointers, occupancy, flags around vr_fifo_mem.
// Define VR_FIFO_PROTOCOL_CHECK_EN to embed handshake assertions.
module vr_fifo
    import vr_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AFULL_LVL = 3,
    parameter int CNT_W     = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFUL_C = CNT_W'(AFULL_LVL);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Handshake flags and next pointer/occupancy values
    always_comb begin
        s_ready     = !rst && (count_q != FULL_C);
        m_valid     = (count_q != '0);
        almost_full = (count_q >= AFUL_C);
        push        = s_valid && s_ready;
        pop         = m_valid && m_ready;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

    vr_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (s_data),
        .raddr (rd_ptr_q),
        .rdata (m_data)
    );

`ifdef VR_FIFO_PROTOCOL_CHECK_EN
    a_rst_ready: assert property (@(posedge clk)
        rst |=> !s_ready)
        else $error("a_rst_ready");

    a_s_hold: assert property (@(posedge clk) disable iff (rst)
        s_valid && !s_ready |=> s_valid && $stable(s_data))
        else $error("a_s_hold");

    a_m_hold: assert property (@(posedge clk) disable iff (rst)
        m_valid && !m_ready |=> m_valid && $stable(m_data))
        else $error("a_m_hold");

    a_cnt_max: assert property (@(posedge clk) disable iff (rst)
        count_q <= FULL_C)
        else $error("a_cnt_max");

    a_valid_cnt: assert property (@(posedge clk) disable iff (rst)
        !(m_valid == 1'b0 && count_q != '0))
        else $error("a_valid_cnt");
`endif

endmodule

// File: tb/tb_vr_fifo.sv
// Self-checking bench for vr_fifo against a queue reference model.
// Inputs change at negedge; outputs are compared at negedge.
module tb_vr_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          m_ready = 1'b0;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [CW-1:0] count;
    logic          almost_full;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mq[$];

    always #5 clk = ~clk;

    vr_fifo #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    // Drive one cycle from a negedge and advance the reference queue
    task automatic cycle(input logic v, input logic [DW-1:0] d,
                         input logic r, output logic pushed,
                         output logic popped);
        s_valid = v;
        s_data  = d;
        m_ready = r;
        pushed  = v && !rst && (mq.size() < DEPTH);
        popped  = r && (mq.size() > 0);
        @(posedge clk);
        if (popped) void'(mq.pop_front());
        if (pushed) mq.push_back(d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        s_valid = 1'b1;
        s_data  = 8'hEE;
        rst     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_s_ready cyc %0d got %b exp 0", i, s_ready);
            end
            n_tests++;
            if (m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_m_valid cyc %0d got %b exp 0", i, m_valid);
            end
            n_tests++;
            if (count !== '0) begin
                n_fail++;
                $display("FAIL rst_count cyc %0d got %0d exp 0", i, count);
            end
        end
        s_valid = 1'b0;
        rst     = 1'b0;
        mq.delete();
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_s_ready got %b exp 1", s_ready);
        end
        n_tests++;
        if (count !== '0) begin
            n_fail++;
            $display("FAIL rel_count got %0d exp 0", count);
        end
    endtask

    task automatic test_single();
        logic pu, po;
        cycle(1'b1, 8'hA5, 1'b0, pu, po);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_head got v=%b d=%h exp v=1 d=a5",
                     m_valid, m_data);
        end
        n_tests++;
        if (count !== CW'(1)) begin
            n_fail++;
            $display("FAIL single_count got %0d exp 1", count);
        end
        cycle(1'b0, 8'h00, 1'b1, pu, po);
        n_tests++;
        if (count !== '0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop got cnt=%0d v=%b exp cnt=0 v=0",
                     count, m_valid);
        end
    endtask

    task automatic test_fill();
        logic pu, po;
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, DW'(i), 1'b0, pu, po);
            n_tests++;
            if (almost_full !== (i >= AFL)) begin
                n_fail++;
                $display("FAIL fill_afull push %0d got %b exp %b",
                         i, almost_full, (i >= AFL));
            end
        end
        n_tests++;
        if (s_ready !== 1'b0 || count !== CW'(4)) begin
            n_fail++;
            $display("FAIL fill_full got rdy=%b cnt=%0d exp rdy=0 cnt=4",
                     s_ready, count);
        end
        cycle(1'b1, 8'h05, 1'b0, pu, po);
        n_tests++;
        if (count !== CW'(4) || m_data !== 8'h01) begin
            n_fail++;
            $display("FAIL fill_hold got cnt=%0d d=%h exp cnt=4 d=01",
                     count, m_data);
        end
    endtask

    task automatic test_drain();
        logic pu, po;
        logic [DW-1:0] exp_head [4];
        logic          rseq     [4];
        exp_head = '{8'h02, 8'h02, 8'h03, 8'h03};
        rseq     = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, rseq[i], pu, po);
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== exp_head[i]) begin
                n_fail++;
                $display("FAIL drain_head step %0d got %h exp %h",
                         i, m_data, exp_head[i]);
            end
            n_tests++;
            if (s_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_ready step %0d got %b exp 1", i, s_ready);
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (m_data !== DW'(3 + i)) begin
                n_fail++;
                $display("FAIL drain_tail %0d got %h exp %h",
                         i, m_data, DW'(3 + i));
            end
            cycle(1'b0, 8'h00, 1'b1, pu, po);
        end
        n_tests++;
        if (m_valid !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL drain_empty got v=%b cnt=%0d exp v=0 cnt=0",
                     m_valid, count);
        end
    endtask

    task automatic test_concurrent();
        logic pu, po;
        cycle(1'b1, 8'h10, 1'b0, pu, po);
        cycle(1'b1, 8'h11, 1'b0, pu, po);
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (m_data !== DW'(8'h10 + i)) begin
                n_fail++;
                $display("FAIL conc_order %0d got %h exp %h",
                         i, m_data, DW'(8'h10 + i));
            end
            cycle(1'b1, DW'(8'h12 + i), 1'b1, pu, po);
            n_tests++;
            if (count !== CW'(2)) begin
                n_fail++;
                $display("FAIL conc_count %0d got %0d exp 2", i, count);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic pu, po;
        cycle(1'b1, 8'h1C, 1'b0, pu, po);
        n_tests++;
        if (count !== CW'(3)) begin
            n_fail++;
            $display("FAIL mid_pre got %0d exp 3", count);
        end
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        mq.delete();
        n_tests++;
        if (count !== '0 || m_valid !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async got cnt=%0d v=%b rdy=%b exp 0 0 0",
                     count, m_valid, s_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'h5A, 1'b0, pu, po);
        n_tests++;
        if (m_data !== 8'h5A || count !== CW'(1)) begin
            n_fail++;
            $display("FAIL mid_fresh got d=%h cnt=%0d exp d=5a cnt=1",
                     m_data, count);
        end
        cycle(1'b0, 8'h00, 1'b1, pu, po);
        n_tests++;
        if (m_valid !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL mid_stale got v=%b cnt=%0d exp v=0 cnt=0",
                     m_valid, count);
        end
    endtask

    task automatic test_random();
        logic          pu, po;
        logic          v, r, pend;
        logic [DW-1:0] d;
        pend = 1'b0;
        v    = 1'b0;
        d    = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                v = ($urandom % 3) != 0;
                d = DW'($urandom);
            end
            r = (i < 200) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            n_tests++;
            if (count !== CW'(mq.size())
                || s_ready !== (mq.size() != DEPTH)
                || m_valid !== (mq.size() != 0)
                || almost_full !== (mq.size() >= AFL)) begin
                n_fail++;
                $display("FAIL rnd_flags %0d got c=%0d r=%b v=%b a=%b exp c=%0d",
                         i, count, s_ready, m_valid, almost_full, mq.size());
            end
            if (mq.size() != 0) begin
                n_tests++;
                if (m_data !== mq[0]) begin
                    n_fail++;
                    $display("FAIL rnd_data %0d got %h exp %h",
                             i, m_data, mq[0]);
                end
            end
            cycle(v, d, r, pu, po);
            pend = v && !pu;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_concurrent();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
